// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: stage bundle widths, ID/EX control
// field layout, NOP control word and the skid occupancy encoding.
package pipe_pkg;

   localparam int DEF_CTRL_W = 16;
   localparam int DEF_DATA_W = 128;
   localparam int DEF_CNT_W  = 32;

   localparam int IFID_CTRL_W  = 16;
   localparam int IFID_DATA_W  = 64;
   localparam int IDEX_CTRL_W  = 16;
   localparam int IDEX_DATA_W  = 128;
   localparam int EXMEM_CTRL_W = 16;
   localparam int EXMEM_DATA_W = 96;
   localparam int MEMWB_CTRL_W = 16;
   localparam int MEMWB_DATA_W = 72;

   localparam int IDEX_REGWRITE_BIT = 0;
   localparam int IDEX_MEMREAD_BIT  = 1;
   localparam int IDEX_MEMWRITE_BIT = 2;
   localparam int IDEX_MEMTOREG_BIT = 3;
   localparam int IDEX_ALUSRC_BIT   = 4;
   localparam int IDEX_REGDST_BIT   = 5;
   localparam int IDEX_BRANCH_BIT   = 6;
   localparam int IDEX_JUMP_BIT     = 7;
   localparam int IDEX_ALUCTRL_LSB  = 8;
   localparam int IDEX_ALUCTRL_W    = 4;

   localparam logic [DEF_CTRL_W-1:0] NOP_CTRL = '0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd3
   } skid_state_t;

   function automatic skid_state_t skid_state(input logic mv, input logic sv);
      if (sv)
         return ST_FULL;
      else if (mv)
         return ST_ONE;
      else
         return ST_EMPTY;
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module pipe_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register with valid/ready handshake, 2-entry skid, flush and bubbles.
// Optional statistics counters are built when PIPE_STAT_EN is defined.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              Clk,
   input  logic              rst_n,
   input  logic              Flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              m_valid;
   logic              s_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] s_data;

   logic        accept;
   logic        drain;
   skid_state_t state;

   logic m_valid_nxt;
   logic s_valid_nxt;
   logic load_m;
   logic load_s;
   logic m_from_s;

   assign in_ready  = ~s_valid;
   assign out_valid = m_valid;
   assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
   assign out_data  = m_data;

   assign accept = in_valid & in_ready;
   assign drain  = m_valid & out_ready;
   assign state  = skid_state(m_valid, s_valid);

   always_comb begin
      m_valid_nxt = m_valid;
      s_valid_nxt = s_valid;
      load_m      = 1'b0;
      load_s      = 1'b0;
      m_from_s    = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (accept) begin
               load_m      = 1'b1;
               m_valid_nxt = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               load_m = 1'b1;
            end else if (accept) begin
               load_s      = 1'b1;
               s_valid_nxt = 1'b1;
            end else if (drain) begin
               m_valid_nxt = 1'b0;
            end
         end
         ST_FULL: begin
            if (drain) begin
               load_m      = 1'b1;
               m_from_s    = 1'b1;
               s_valid_nxt = 1'b0;
            end
         end
         default: begin
            m_valid_nxt = 1'b0;
            s_valid_nxt = 1'b0;
         end
      endcase
      // Squash beats every other event; nothing is loaded either.
      if (Flush) begin
         m_valid_nxt = 1'b0;
         s_valid_nxt = 1'b0;
         load_m      = 1'b0;
         load_s      = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_ctrl  <= '0;
         m_data  <= '0;
         s_ctrl  <= '0;
         s_data  <= '0;
      end else begin
         m_valid <= m_valid_nxt;
         s_valid <= s_valid_nxt;
         if (load_m) begin
            m_ctrl <= m_from_s ? s_ctrl : in_ctrl;
            m_data <= m_from_s ? s_data : in_data;
         end
         if (load_s) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
         end
      end
   end

`ifdef PIPE_STAT_EN
   logic stall_inc;
   logic bubble_inc;

   assign stall_inc  = m_valid & ~out_ready;
   assign bubble_inc = ~m_valid;

   pipe_sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (Clk),
      .rst_n(rst_n),
      .inc  (stall_inc),
      .clr  (stat_clr),
      .cnt  (stall_cnt)
   );

   pipe_sat_counter #(
      .CNT_W(CNT_W)
   ) u_bubble_cnt (
      .clk  (Clk),
      .rst_n(rst_n),
      .inc  (bubble_inc),
      .clr  (stat_clr),
      .cnt  (bubble_cnt)
   );
`else
   logic unused_stat_clr;

   assign unused_stat_clr = stat_clr;
   assign stall_cnt       = '0;
   assign bubble_cnt      = '0;
`endif

endmodule
